// File: rtl/lfsr_crypt_engine.sv
// LFSR stream-cipher bus master: reads config and message from data memory, writes cipher/plain text back.
// Latency req->ack 7+2*MSG_LEN cycles (7 on bad pt_no); fixed 2-cycle slot per byte, no backpressure.
module lfsr_crypt_engine #(
  parameter int LFSR_W   = 7,
  parameter int MSG_LEN  = 64,
  parameter int MAX_STR  = 49,
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = 0,
  parameter int CFG_BASE = 61,
  parameter int DST_BASE = 64,
  parameter int NUM_PTRN = 9,
  parameter logic [LFSR_W-1:0] TAP_TABLE [NUM_PTRN] =
    '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B}
) (
  input  logic              clk,
  input  logic              init,
  input  logic              req,
  input  logic              mode,
  output logic              ack,
  output logic              err,
  output logic [6:0]        parity_errs,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [LFSR_W:0]   mem_wdata,
  input  logic [LFSR_W:0]   mem_rdata
);
  localparam int DW    = LFSR_W + 1;
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int CW0   = (DW > IDX_W) ? DW : IDX_W;
  localparam int CW    = ((CW0 > ADDR_W) ? CW0 : ADDR_W) + 2;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MSG_LEN - 1);
  localparam logic [LFSR_W-1:0] PAD_CHR  = LFSR_W'(32);

  typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        cfg_cnt;
  logic [IDX_W-1:0]  idx;
  logic              phase;
  logic              mode_q;
  logic              term;
  logic [DW-1:0]     pre_len;
  logic [DW-1:0]     pt_no;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] taps;
  logic [LFSR_W-1:0] lfsr_nxt;

  logic              pt_bad;
  logic              before_pre;
  logic              past_max;
  logic              src_live;
  logic              src_zero;
  logic              par_bad;
  logic              last_idx;
  logic [CW-1:0]     i_ext;
  logic [CW-1:0]     pre_ext;
  logic [CW-1:0]     j_off;
  logic [LFSR_W-1:0] pchr;
  logic [LFSR_W-1:0] xr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic [DW-1:0]     wr_dat;

  always_comb begin
    taps = '0;
    for (int k = 0; k < NUM_PTRN; k++) begin
      if (pt_no == DW'(k)) taps = TAP_TABLE[k];
    end
  end

  assign pt_bad   = pt_no >= DW'(NUM_PTRN);
  assign lfsr_nxt = {lfsr[LFSR_W-2:0], ^(lfsr & taps)};
  assign ack      = (state == DONE);

  // j_off is the source-string offset; only meaningful once idx has passed pre_len
  always_comb begin
    i_ext      = CW'(idx);
    pre_ext    = CW'(pre_len);
    j_off      = i_ext - pre_ext;
    before_pre = i_ext < pre_ext;
    past_max   = j_off >= CW'(MAX_STR);
    src_live   = !before_pre && !past_max && !term;
    src_zero   = (mem_rdata == '0);
    par_bad    = mem_rdata[LFSR_W] != ^mem_rdata[LFSR_W-1:0];
    last_idx   = (idx == LAST_IDX);
    rd_addr    = '0;
    wr_addr    = '0;
    wr_en      = 1'b0;
    wr_dat     = '0;
    pchr       = PAD_CHR;
    xr         = '0;
    if (mode_q) begin
      rd_addr = ADDR_W'(SRC_BASE) + ADDR_W'(idx);
      wr_addr = ADDR_W'(DST_BASE) + j_off[ADDR_W-1:0];
      xr      = mem_rdata[LFSR_W-1:0] ^ lfsr;
      wr_en   = !before_pre;
      wr_dat  = {1'b0, xr};
    end else begin
      rd_addr = ADDR_W'(SRC_BASE) + j_off[ADDR_W-1:0];
      wr_addr = ADDR_W'(DST_BASE) + ADDR_W'(idx);
      if (src_live && !src_zero) pchr = mem_rdata[LFSR_W-1:0];
      xr      = pchr ^ lfsr;
      wr_en   = 1'b1;
      wr_dat  = {^xr, xr};
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory port is driven combinationally from state so reset silences it at once
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE, DONE: begin
        if (req) state_nxt = CFG;
      end
      CFG: begin
        if (cfg_cnt[0]) mem_addr = ADDR_W'(CFG_BASE) + ADDR_W'(cfg_cnt[2:1]);
        if (cfg_cnt == 3'd6) state_nxt = pt_bad ? DONE : RUN;
      end
      RUN: begin
        if (!phase) begin
          mem_addr = rd_addr;
        end else begin
          if (wr_en) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_dat;
          end
          if (last_idx) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      cfg_cnt     <= '0;
      idx         <= '0;
      phase       <= 1'b0;
      mode_q      <= 1'b0;
      term        <= 1'b0;
      pre_len     <= '0;
      pt_no       <= '0;
      lfsr        <= LFSR_W'(1);
      err         <= 1'b0;
      parity_errs <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req) begin
            mode_q      <= mode;
            err         <= 1'b0;
            parity_errs <= '0;
            cfg_cnt     <= '0;
          end
        end
        CFG: begin
          cfg_cnt <= cfg_cnt + 3'd1;
          case (cfg_cnt)
            3'd2: pre_len <= mem_rdata;
            3'd4: pt_no   <= mem_rdata;
            3'd6: begin
              lfsr  <= (mem_rdata[LFSR_W-1:0] == '0) ? LFSR_W'(1) : mem_rdata[LFSR_W-1:0];
              idx   <= '0;
              phase <= 1'b0;
              term  <= 1'b0;
              err   <= pt_bad;
            end
            default: ;
          endcase
        end
        RUN: begin
          phase <= ~phase;
          if (phase) begin
            idx  <= idx + 1'b1;
            lfsr <= lfsr_nxt;
            if (!mode_q && src_live && src_zero) term <= 1'b1;
            if (mode_q && par_bad && parity_errs != 7'h7F) parity_errs <= parity_errs + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lfsr_crypt_engine.md
# lfsr_crypt_engine

Hardware LFSR stream-cipher engine replacing the software encryption program in the programmable CPU's data-memory workspace. On request it reads a configuration block and a source message from data memory, runs a parametrised maximal-length LFSR, and writes an encrypted (or decrypted) message back to data memory with a parity bit in each MSB. It is a memory-mapped bus master beside the CPU and uses the same single-port data memory with one-cycle read latency.

## Interface
- LFSR_W, 7: LFSR and character width; data byte width is LFSR_W+1.
- MSG_LEN, 64: padded message length in bytes.
- MAX_STR, 49: maximum raw string length.
- ADDR_W, 8: memory address width.
- SRC_BASE, 0: source message base address.
- CFG_BASE, 61: config block: CFG_BASE = pre_length, +1 = pt_no, +2 = lfsr_init.
- DST_BASE, 64: result base address.
- NUM_PTRN, 9: tap-table entries.
- TAP_TABLE, {7'h60,7'h48,7'h78,7'h72,7'h6A,7'h69,7'h5C,7'h7E,7'h7B}: feedback tap patterns, entry 0 first.
- clk  in  1  clock; all state changes on the rising edge.
- init  in  1  reset; one clock, reset is asynchronous and active-low.
- req  in  1  start request, level-sampled in IDLE/DONE.
- mode  in  1  0 = encrypt, 1 = decrypt; latched at start.
- ack  out  1  run complete; high in DONE.
- err  out  1  config error (pt_no >= NUM_PTRN); valid while ack.
- parity_errs  out  7  decrypt parity-mismatch count; valid while ack.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  LFSR_W+1  write data.
- mem_rdata  in  LFSR_W+1  read data, valid the cycle after the address.

## Operation
- States: IDLE -> CFG -> RUN -> DONE. With req high in IDLE or DONE, the engine latches mode, clears err and parity_errs, and enters CFG. req is ignored in CFG and RUN.
- CFG: reads the three config bytes, 2 cycles each. An lfsr_init value of 0 is replaced by 1. If pt_no >= NUM_PTRN, the engine sets err and goes to DONE with no memory writes. pre_length is not range-checked.
- LFSR step: s' = {s[LFSR_W-2:0], ^(s & taps)}. Index i uses state s_i, with s_0 = lfsr_init.
- Encrypt, i = 0..MSG_LEN-1:
  - Plain character p = space (0x20) if i < pre_length, if i-pre_length >= MAX_STR, or once a 0x00 source byte has been seen (terminator, sticky). Otherwise p = mem[SRC_BASE+i-pre_length].
  - x = p[LFSR_W-1:0] ^ s_i.
  - Write {^x, x} to DST_BASE+i.
- Decrypt, i = 0..MSG_LEN-1:
  - Read c = mem[SRC_BASE+i].
  - If c[MSB] != ^c[LFSR_W-1:0], increment parity_errs, saturating at 127.
  - If i >= pre_length, write {1'b0, c[LFSR_W-1:0]^s_i} to DST_BASE+i-pre_length.
- Every index takes a fixed 2 cycles (address/read, then write or idle slot), including pad indices.
- Addresses wrap modulo 2^ADDR_W.

## Timing
- Reset values: state IDLE, ack 0, err 0, parity_errs 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Asserting init mid-run forces mem_we low immediately and returns the engine to IDLE. A write in flight is aborted and partial results are undefined.
- Latency from the req-sampling edge to ack high:
  - 1 + 6 + 2*MSG_LEN cycles; 135 with default parameters.
  - 1 + 6 cycles on a config error.
- ack stays high until req is sampled high again, which starts a new run. ack drops in the first CFG cycle.
- mem_we is a one-cycle pulse, and mem_addr and mem_wdata are stable in that cycle.
- No two writes occur in consecutive cycles.

## Test plan
- Encrypt "Mr. Watson, come here. I want to see you.", pre_length 10, pt_no 0, lfsr_init 0x01:
  - DST[64] = 0x21 and DST[65] = 0x22.
  - All 64 bytes match the software model.
  - ack at cycle 135.
- Round trip: run an encrypt, copy the result to SRC, run a decrypt with the same config.
  - DST[64..] equals the original string followed by spaces.
  - parity_errs = 0.
- Decrypt with bit 0 flipped in 3 crypto bytes -> parity_errs = 3, and the affected plaintext bytes differ in bit 0 only.
- pt_no = 9 -> err = 1, ack after 7 cycles, no mem_we pulses.
- lfsr_init = 0 -> output identical to the lfsr_init = 1 run.
- Terminator and reset cases:
  - A 0x00 at SRC[5] pads all later indices with spaces.
  - init low at RUN index 20 -> mem_we drops asynchronously, state is IDLE, ack stays 0.
  - A following req completes a clean run.
